// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, parity/stop checking and a show-ahead
// receive FIFO; completed frames are pushed with their error flags attached.
module uart_rx_fifo #(
  parameter int DIVIDER   = 217,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         rxd,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_frame_err,
  output logic                         rx_parity_err,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         overrun,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DIVIDER);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int WW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIVIDER / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta, rxs;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr_q, ferr_q;
  logic                   push_q;
  logic [WW-1:0]          word_q;
  logic                   cnt_clr, bit_clr, bit_inc, frame_clr;
  logic                   do_shift, do_par, do_stop, push_d;
  logic                   at_end, par_bit;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign at_end  = (cnt_q == CNT_LAST);
  assign par_bit = (PARITY == 1) ? ~^shreg : ^shreg;

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    frame_clr = 1'b0;
    do_shift  = 1'b0;
    do_par    = 1'b0;
    do_stop   = 1'b0;
    push_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_clr   = 1'b1;
          bit_clr   = 1'b1;
          frame_clr = 1'b1;
          state_d   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_end) begin
          cnt_clr  = 1'b1;
          do_shift = 1'b1;
          bit_inc  = 1'b1;
          if (bit_q == DATA_LAST) begin
            bit_clr = 1'b1;
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (at_end) begin
          cnt_clr = 1'b1;
          do_par  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (at_end) begin
          cnt_clr = 1'b1;
          do_stop = 1'b1;
          bit_inc = 1'b1;
          if (bit_q == STOP_LAST) begin
            // the push itself lands one clock later from push_q/word_q
            bit_clr = 1'b1;
            push_d  = 1'b1;
            state_d = (ferr_q || !rxs) ? WAIT_IDLE : IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_clr ? '0 : cnt_q + CW'(1);
      if (bit_clr)      bit_q <= '0;
      else if (bit_inc) bit_q <= bit_q + BW'(1);
      if (frame_clr) begin
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (do_shift)         shreg  <= {rxs, shreg[DATA_BITS-1:1]};
      if (do_par)           perr_q <= (rxs != par_bit);
      if (do_stop && !rxs)  ferr_q <= 1'b1;
      push_q <= push_d;
      if (push_d) word_q <= {perr_q, ferr_q | ~rxs, shreg};
    end
  end

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count_q;
  logic          full, pop, push_ok, overrun_q;
  logic [WW-1:0] head;

  assign full    = (count_q == FULL_CNT);
  assign rx_valid = (count_q != '0);
  assign pop     = rx_valid & rx_ready;
  // a simultaneous pop frees the slot, so a full FIFO still accepts the word
  assign push_ok = push_q & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= word_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + NW'(1);
      else if (!push_ok && pop) count_q <= count_q - NW'(1);
      overrun_q <= push_q & full & ~pop;
    end
  end

  assign head          = mem[rd_ptr];
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid & head[DATA_BITS];
  assign rx_parity_err = rx_valid & head[DATA_BITS+1];
  assign overrun       = overrun_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised by a stimulus
// process, expected entries queued from the sent bits, and a consumer pops/compares.
module tb_uart_rx_fifo;
  localparam int DIV = 16;
  localparam int DB  = 8;
  localparam int PAR = 2;
  localparam int SB  = 1;
  localparam int DEP = 4;
  localparam int NW  = $clog2(DEP + 1);
  localparam int PB  = (PAR != 0) ? 1 : 0;
  // clocks from the first edge after the start fall to the push edge
  localparam int LAT = 2 + DIV / 2 + DIV * (DB + PB + SB) + 1;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_frame_err, rx_parity_err, rx_valid, overrun;
  logic [NW-1:0] fifo_count;

  uart_rx_fifo #(.DIVIDER(DIV), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .DEPTH(DEP)) dut (
    .clk(clk), .resetb(resetb), .rxd(rxd), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
    .fifo_count(fifo_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          perr;
    logic          ferr;
    logic [DB-1:0] data;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0, passes = 0;
  int ovr_seen = 0, ovr_exp = 0;
  bit consume_en = 1'b0;
  int force_pop_cyc = -1;
  int rise_cyc = -1;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  // consumer + scoreboard: picks rx_ready for the coming edge and checks any pop it causes
  initial begin
    entry_t e;
    bit rdy;
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (overrun) ovr_seen++;
      rdy = consume_en ? ($urandom_range(0, 3) != 0) : (cyc == force_pop_cyc);
      rx_ready = rdy;
      if (rdy && rx_valid) begin
        check("entry_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("head_data", int'(rx_data), int'(e.data));
          check("head_perr", int'(rx_parity_err), int'(e.perr));
          check("head_ferr", int'(rx_frame_err), int'(e.ferr));
        end
      end
    end
  end

  task automatic model_push(input entry_t e, input int t0);
    if (exp_q.size() < DEP || force_pop_cyc == t0 + LAT) exp_q.push_back(e);
    else ovr_exp++;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit bad_par, input bit bad_stop,
                            input int low_bits, input bit force_pop, output int t0);
    entry_t e;
    logic good;
    @(negedge clk);
    t0 = cyc;
    if (force_pop) force_pop_cyc = t0 + LAT;
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (DIV) @(negedge clk);
    end
    good = (PAR == 1) ? ~^d : ^d;
    if (PAR != 0) begin
      rxd = bad_par ? ~good : good;
      repeat (DIV) @(negedge clk);
    end
    e.data = d;
    e.perr = (PAR != 0) && bad_par;
    e.ferr = bad_stop;
    for (int s = 0; s < SB; s++) begin
      rxd = (bad_stop && s == SB - 1) ? 1'b0 : 1'b1;
      if (s == SB - 1) model_push(e, t0);
      repeat (DIV) @(negedge clk);
    end
    repeat (low_bits * DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", int'(exp_q.size() == 0 && !rx_valid), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(rx_valid), 0);
    check({tag, "_count"}, int'(fifo_count), 0);
    check({tag, "_data"}, int'(rx_data), 0);
    check({tag, "_ferr"}, int'(rx_frame_err), 0);
    check({tag, "_perr"}, int'(rx_parity_err), 0);
    check({tag, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    int t0;
    logic [DB-1:0] v;
    bit bp, bs;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (5) @(negedge clk);

    // single 'H' frame: latency, count and head contents
    send_frame(8'h48, 1'b0, 1'b0, 0, 1'b0, t0);
    repeat (4) @(negedge clk);
    check("h_latency", rise_cyc - t0, LAT + 1);
    check("h_count", int'(fifo_count), 1);
    check("h_data", int'(rx_data), 'h48);
    check("h_ferr", int'(rx_frame_err), 0);
    check("h_perr", int'(rx_parity_err), 0);
    consume_en = 1'b1;
    drain();

    // even parity: wrong then right parity bit
    send_frame(8'h41, 1'b1, 1'b0, 0, 1'b0, t0);
    send_frame(8'h41, 1'b0, 1'b0, 0, 1'b0, t0);
    drain();

    // stop bit low followed by a 40 bit-time break
    consume_en = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 40, 1'b0, t0);
    repeat (DIV) @(negedge clk);
    check("brk_count", int'(fifo_count), 1);
    check("brk_ferr", int'(rx_frame_err), 1);
    consume_en = 1'b1;
    drain();
    send_frame(8'hC3, 1'b0, 1'b0, 0, 1'b0, t0);
    drain();

    // 3-clock glitch is a false start
    consume_en = 1'b0;
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("glitch_count", int'(fifo_count), 0);
    check("glitch_valid", int'(rx_valid), 0);

    // fill to DEPTH, overflow once, then full push coinciding with a pop
    for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b0, 1'b0, 0, 1'b0, t0);
    repeat (4) @(negedge clk);
    check("ovr_pulses", ovr_seen, ovr_exp);
    check("ovr_once", ovr_seen, 1);
    check("ovr_count", int'(fifo_count), DEP);
    send_frame(8'h06, 1'b0, 1'b0, 0, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("fullpop_ovr", ovr_seen, 1);
    check("fullpop_count", int'(fifo_count), DEP);
    force_pop_cyc = -1;

    // reset in the middle of the data bits of 0x55
    check("pre_reset_valid", int'(rx_valid), 1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    v = 8'h55;
    for (int i = 0; i < 4; i++) begin
      rxd = v[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = v[4];
    repeat (DIV / 2) @(negedge clk);
    resetb = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hAA, 1'b0, 1'b0, 0, 1'b0, t0);
    consume_en = 1'b1;
    drain();

    // randomized frames with occasional parity/stop errors and breaks
    for (int k = 0; k < 24; k++) begin
      v  = DB'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 5) == 0);
      send_frame(v, bp, bs, bs ? $urandom_range(0, 3) : 0, 1'b0, t0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    drain();
    check("ovr_total", ovr_seen, ovr_exp);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DIVIDER, default 217, clocks per bit (BAUD = f_clk/DIVIDER), legal range >= 8.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-003 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-005 Parameter DEPTH, default 16, FIFO entries, power of 2, >= 2.
REQ-006 clk  input  1  system clock; all logic on posedge.
REQ-007 resetb  input  1  asynchronous active-low reset.
REQ-008 rxd  input  1  serial data; idle high; asynchronous to clk.
REQ-009 rx_data  output  DATA_BITS  FIFO head data, LSB = first bit received.
REQ-010 rx_frame_err  output  1  FIFO head entry had a stop-bit error.
REQ-011 rx_parity_err  output  1  FIFO head entry had a parity mismatch; 0 when PARITY=0.
REQ-012 rx_valid  output  1  FIFO non-empty.
REQ-013 rx_ready  input  1  consumer accepts head.
REQ-014 overrun  output  1  one-cycle pulse: completed frame dropped.
REQ-015 fifo_count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-016 rxd SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the second flop (rxs).
REQ-017 FSM states SHALL be IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
REQ-018 IDLE: rxs == 0 -> START, with the bit counter cleared on that cycle.
REQ-019 START: sample at count DIVIDER/2-1; if rxs == 1, the start is false -> IDLE with no push; else -> DATA with the counter cleared.
REQ-020 After START, each sample SHALL occur when the counter reaches DIVIDER-1, then the counter clears; the sampling instant is therefore mid-bit.
REQ-021 DATA: shift DATA_BITS samples LSB first -> PAR if PARITY != 0, else STOP.
REQ-022 PAR: one sample; parity error if (XOR of data ^ sample) != (PARITY==1 ? 1 : 0).
REQ-023 STOP: STOP_BITS samples; frame error if any sample is 0.
REQ-024 After the last stop sample, the word {parity_err, frame_err, data} SHALL be pushed on the next clk; push happens even when error flags are set.
REQ-025 After a push: no frame error -> IDLE; frame error -> WAIT_IDLE.
REQ-026 WAIT_IDLE: stay until rxs == 1, then -> IDLE; this covers break conditions and prevents a second push during a long low.
REQ-027 The FIFO SHALL be show-ahead: rx_data and flags reflect the head whenever rx_valid = 1; a pop occurs on a clk where rx_valid && rx_ready.
REQ-028 Outputs SHALL be first-word-fall-through: rx_valid rises the cycle after a push into an empty FIFO.
REQ-029 Push when full without a simultaneous pop: drop the word, pulse overrun for 1 cycle, leave contents and fifo_count unchanged.
REQ-030 Push and pop on the same clk when full: push is accepted; fifo_count is unchanged; no overrun.
REQ-031 Push and pop on the same clk when empty: not possible; the pushed word appears the next cycle.
REQ-032 Pointers SHALL wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
REQ-033 rx_ready while rx_valid = 0 SHALL have no effect.
REQ-034 rxd edges during DATA/PAR/STOP SHALL NOT resynchronize the bit counter.

Reset
REQ-035 resetb low SHALL force: FSM IDLE, counters 0, synchronizer 1s, FIFO empty, fifo_count 0, rx_valid 0, overrun 0, rx_frame_err 0, rx_parity_err 0, rx_data 0, immediately and asynchronously.
REQ-036 A frame in progress at reset SHALL be discarded; reception resumes from IDLE after resetb rises.

Verification
REQ-037 DIVIDER=16, 8N1: send 0x48 ("H") -> rx_valid after final stop sample +1 clk; rx_data 0x48; both flags 0; fifo_count 1.
REQ-038 PARITY=2: send 0x41 with parity bit 1 (correct is 0) -> rx_parity_err 1, rx_data 0x41; repeat with parity bit 0 -> rx_parity_err 0.
REQ-039 Stop bit driven 0, then rxd held low 40 bit-times -> exactly one entry, rx_frame_err 1; next valid frame after rxd returns high -> received correctly.
REQ-040 rxd low pulse of 3 clocks (DIVIDER=16) -> no push, FSM back in IDLE, fifo_count 0.
REQ-041 DEPTH=4, rx_ready=0, send 0x01..0x05 -> overrun pulses once on the 5th frame; fifo_count 4; pops yield 0x01..0x04 in order; 5th frame completing while rx_ready=1 and full -> accepted, no overrun.
REQ-042 resetb low mid-DATA of 0x55 -> all outputs at reset values; after release, 0xAA -> rx_data 0xAA, no error flags.
